atm_txn_arbiter: RTL and testbench

- Shares one account-balance store between N_TERM ATM terminal front-ends.
- Each terminal issues balance/deposit/withdraw transactions via valid/ready.
- Round-robin arbitration grants one transaction at a time; each executes as an atomic read-modify-write.
- Sits between the per-terminal session FSMs and the balance register file, which it owns.

---
 rtl/atm_pkg.sv | 31 +++
 rtl/atm_txn_arbiter_rr.sv | 41 ++++
 rtl/atm_txn_arbiter.sv | 239 +++++++++++++++++++++++
 tb/tb_atm_txn_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : atm_pkg
// Description : Shared op codes, FSM state encoding and default widths for
//               the ATM transaction arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package atm_pkg;

    // Transaction op codes carried on req_op
    localparam logic [1:0] OP_BAL = 2'b00;
    localparam logic [1:0] OP_DEP = 2'b01;
    localparam logic [1:0] OP_WDR = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    // Default datapath widths
    localparam int ATM_BAL_W  = 18;
    localparam int ATM_AMT_W  = 12;
    localparam int ATM_ACCT_W = 3;

    // Transaction sequencer states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GRANT = 3'd1,
        READ  = 3'd2,
        EXEC  = 3'd3,
        RESP  = 3'd4
    } atm_state_t;

endpackage : atm_pkg
`default_nettype wire

// File: rtl/atm_txn_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : atm_rr_arbiter
// Description : Combinational round-robin search. Starting at ptr and
//               wrapping upward, picks the first asserted request and
//               returns it one-hot plus encoded. Pointer lives in the parent.
// Revision    : 1.0 - initial release
// ============================================================================
module atm_rr_arbiter #(
    parameter int N_TERM = 4,
    parameter int PTR_W  = 2
) (
    input  logic [N_TERM-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    output logic [N_TERM-1:0] grant,
    output logic [2:0]        winner,
    output logic              any
);

    // Rotating priority search; first hit from ptr upward wins
    always_comb begin : p_search
        int idx;
        idx    = 0;
        grant  = '0;
        winner = '0;
        any    = 1'b0;
        for (int i = 0; i < N_TERM; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N_TERM) begin
                idx = idx - N_TERM;
            end
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                winner     = 3'(idx);
            end
        end
    end

endmodule : atm_rr_arbiter
`default_nettype wire

// File: rtl/atm_txn_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : atm_txn_arbiter
// Description : Round-robin arbiter sharing one account-balance store among
//               N_TERM terminals. Each granted transaction runs as an atomic
//               GRANT/READ/EXEC/RESP read-modify-write; the store write lands
//               on the same edge that ends the response cycle.
//               Optional macro ATM_TXN_LOG_EN adds txn_count / last_term.
// Revision    : 1.0 - initial release
// ============================================================================
module atm_txn_arbiter
    import atm_pkg::*;
#(
    parameter int N_TERM      = 4,
    parameter int N_ACCT      = 8,
    parameter int ACCT_W      = ATM_ACCT_W,
    parameter int BAL_W       = ATM_BAL_W,
    parameter int AMT_W       = ATM_AMT_W,
    parameter int MAX_DEPOSIT = 2000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_TERM-1:0]        req_valid,
    output logic [N_TERM-1:0]        req_ready,
    input  logic [2*N_TERM-1:0]      req_op,
    input  logic [ACCT_W*N_TERM-1:0] req_acct,
    input  logic [AMT_W*N_TERM-1:0]  req_amt,
    output logic                     rsp_valid,
    output logic [2:0]               rsp_term,
    output logic                     rsp_ok,
    output logic [BAL_W-1:0]         rsp_balance,
    input  logic                     cfg_we,
    input  logic [ACCT_W-1:0]        cfg_acct,
    input  logic [BAL_W-1:0]         cfg_balance,
    output logic                     busy
`ifdef ATM_TXN_LOG_EN
    ,
    output logic [15:0]              txn_count,
    output logic [2:0]               last_term
`endif
);

    localparam int          PTR_W     = (N_TERM > 1) ? $clog2(N_TERM) : 1;
    localparam logic [31:0] N_ACCT_U  = 32'(N_ACCT);
    localparam logic [31:0] MAX_DEP_U = 32'(MAX_DEPOSIT);

    atm_state_t              state_q, state_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic [1:0]              op_q, op_d;
    logic [ACCT_W-1:0]       acct_q, acct_d;
    logic [AMT_W-1:0]        amt_q, amt_d;
    logic [2:0]              term_q, term_d;
    logic [BAL_W-1:0]        rd_bal_q, rd_bal_d;
    logic                    rsp_ok_q, rsp_ok_d;
    logic [BAL_W-1:0]        rsp_bal_q, rsp_bal_d;
    logic [2:0]              rsp_term_q, rsp_term_d;
    logic [BAL_W-1:0]        bal_q [N_ACCT];
    logic [BAL_W-1:0]        bal_d [N_ACCT];

    logic [N_TERM-1:0]       arb_grant;
    logic [2:0]              arb_winner;
    logic                    arb_any;
    logic [PTR_W-1:0]        ptr_next;

    logic                    acct_valid;
    logic                    cfg_valid;
    logic [BAL_W-1:0]        amt_ext;
    logic [BAL_W:0]          dep_sum;
    logic                    amt_le_max;

    atm_rr_arbiter #(
        .N_TERM (N_TERM),
        .PTR_W  (PTR_W)
    ) u_rr (
        .req    (req_valid),
        .ptr    (ptr_q),
        .grant  (arb_grant),
        .winner (arb_winner),
        .any    (arb_any)
    );

    // Pointer advance and arithmetic helpers; deposit sum carries one extra bit
    always_comb begin
        ptr_next   = (int'(arb_winner) == N_TERM - 1) ? '0 : PTR_W'(arb_winner + 3'd1);
        acct_valid = (32'(acct_q) < N_ACCT_U);
        cfg_valid  = (32'(cfg_acct) < N_ACCT_U);
        amt_ext    = BAL_W'(amt_q);
        dep_sum    = {1'b0, rd_bal_q} + (BAL_W+1)'(amt_q);
        amt_le_max = (32'(amt_q) <= MAX_DEP_U);
    end

    // Sequencer next state; RESP chains straight into GRANT when work is
    // pending so grants are 4 cycles apart, unless a cfg load is requested
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!cfg_we && (|req_valid)) state_d = GRANT;
            GRANT:   state_d = arb_any ? READ : IDLE;
            READ:    state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    state_d = (!cfg_we && (|req_valid)) ? GRANT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: latch winner, read balance, evaluate op, commit on RESP
    always_comb begin
        ptr_d      = ptr_q;
        op_d       = op_q;
        acct_d     = acct_q;
        amt_d      = amt_q;
        term_d     = term_q;
        rd_bal_d   = rd_bal_q;
        rsp_ok_d   = rsp_ok_q;
        rsp_bal_d  = rsp_bal_q;
        rsp_term_d = rsp_term_q;
        bal_d      = bal_q;

        case (state_q)
            IDLE: begin
                if (cfg_we && cfg_valid) begin
                    bal_d[cfg_acct] = cfg_balance;
                end
            end
            GRANT: begin
                if (arb_any) begin
                    op_d   = req_op[int'(arb_winner)*2 +: 2];
                    acct_d = req_acct[int'(arb_winner)*ACCT_W +: ACCT_W];
                    amt_d  = req_amt[int'(arb_winner)*AMT_W +: AMT_W];
                    term_d = arb_winner;
                    ptr_d  = ptr_next;
                end
            end
            READ: begin
                rd_bal_d = acct_valid ? bal_q[acct_q] : '0;
            end
            EXEC: begin
                rsp_term_d = term_q;
                rsp_ok_d   = 1'b0;
                rsp_bal_d  = rd_bal_q;
                if (!acct_valid) begin
                    rsp_bal_d = '0;
                end else begin
                    case (op_q)
                        OP_BAL: rsp_ok_d = 1'b1;
                        OP_DEP: begin
                            if (amt_le_max && !dep_sum[BAL_W]) begin
                                rsp_ok_d  = 1'b1;
                                rsp_bal_d = dep_sum[BAL_W-1:0];
                            end
                        end
                        OP_WDR: begin
                            if (amt_ext <= rd_bal_q) begin
                                rsp_ok_d  = 1'b1;
                                rsp_bal_d = rd_bal_q - amt_ext;
                            end
                        end
                        default: rsp_ok_d = 1'b0;
                    endcase
                end
            end
            RESP: begin
                if (rsp_ok_q && (op_q != OP_BAL)) begin
                    bal_d[acct_q] = rsp_bal_q;
                end
            end
            default: ;
        endcase
    end

    // State and datapath registers; reset clears the whole store
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            op_q       <= OP_BAL;
            acct_q     <= '0;
            amt_q      <= '0;
            term_q     <= '0;
            rd_bal_q   <= '0;
            rsp_ok_q   <= 1'b0;
            rsp_bal_q  <= '0;
            rsp_term_q <= '0;
            for (int a = 0; a < N_ACCT; a++) begin
                bal_q[a] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            op_q       <= op_d;
            acct_q     <= acct_d;
            amt_q      <= amt_d;
            term_q     <= term_d;
            rd_bal_q   <= rd_bal_d;
            rsp_ok_q   <= rsp_ok_d;
            rsp_bal_q  <= rsp_bal_d;
            rsp_term_q <= rsp_term_d;
            bal_q      <= bal_d;
        end
    end

    assign req_ready   = (state_q == GRANT) ? arb_grant : '0;
    assign rsp_valid   = (state_q == RESP);
    assign rsp_ok      = rsp_ok_q;
    assign rsp_balance = rsp_bal_q;
    assign rsp_term    = rsp_term_q;
    assign busy        = (state_q != IDLE);

`ifdef ATM_TXN_LOG_EN
    logic [15:0] txn_count_q, txn_count_d;
    logic [2:0]  last_term_q, last_term_d;

    // Count accepted deposits/withdrawals as they commit
    always_comb begin
        txn_count_d = txn_count_q;
        last_term_d = last_term_q;
        if ((state_q == RESP) && rsp_ok_q && ((op_q == OP_DEP) || (op_q == OP_WDR))) begin
            txn_count_d = txn_count_q + 16'd1;
            last_term_d = rsp_term_q;
        end
    end

    // Transaction log registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txn_count_q <= '0;
            last_term_q <= '0;
        end else begin
            txn_count_q <= txn_count_d;
            last_term_q <= last_term_d;
        end
    end

    assign txn_count = txn_count_q;
    assign last_term = last_term_q;
`endif

endmodule : atm_txn_arbiter
`default_nettype wire

// File: tb/tb_atm_txn_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_atm_txn_arbiter
// Description : Scoreboard bench for atm_txn_arbiter. N_ACCT is set to 6 so
//               out-of-range account indices are reachable.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_atm_txn_arbiter;
    import atm_pkg::*;

    localparam int N_TERM = 4;
    localparam int N_ACCT = 6;
    localparam int ACCT_W = 3;
    localparam int BAL_W  = 18;
    localparam int AMT_W  = 12;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [N_TERM-1:0]        req_valid;
    logic [N_TERM-1:0]        req_ready;
    logic [2*N_TERM-1:0]      req_op;
    logic [ACCT_W*N_TERM-1:0] req_acct;
    logic [AMT_W*N_TERM-1:0]  req_amt;
    logic                     rsp_valid;
    logic [2:0]               rsp_term;
    logic                     rsp_ok;
    logic [BAL_W-1:0]         rsp_balance;
    logic                     cfg_we;
    logic [ACCT_W-1:0]        cfg_acct;
    logic [BAL_W-1:0]         cfg_balance;
    logic                     busy;
`ifdef ATM_TXN_LOG_EN
    logic [15:0]              txn_count;
    logic [2:0]               last_term;
`endif

    typedef struct packed {
        logic [2:0]       term;
        logic             ok;
        logic [BAL_W-1:0] bal;
    } exp_t;

    exp_t exp_q[$];
    int   gq[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    atm_txn_arbiter #(
        .N_TERM      (N_TERM),
        .N_ACCT      (N_ACCT),
        .ACCT_W      (ACCT_W),
        .BAL_W       (BAL_W),
        .AMT_W       (AMT_W),
        .MAX_DEPOSIT (2000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_acct    (req_acct),
        .req_amt     (req_amt),
        .rsp_valid   (rsp_valid),
        .rsp_term    (rsp_term),
        .rsp_ok      (rsp_ok),
        .rsp_balance (rsp_balance),
        .cfg_we      (cfg_we),
        .cfg_acct    (cfg_acct),
        .cfg_balance (cfg_balance),
        .busy        (busy)
`ifdef ATM_TXN_LOG_EN
        ,
        .txn_count   (txn_count),
        .last_term   (last_term)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    endtask

    // Monitor: log grant cycles, check every response against the scoreboard
    always @(negedge clk) begin
        if (rst) begin
            gq.delete();
        end else begin
            if (req_ready != '0) gq.push_back(cyc);
            if (rsp_valid) begin
                chk("rsp_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("rsp_term", 32'(rsp_term), 32'(mon_e.term));
                    chk("rsp_ok", 32'(rsp_ok), 32'(mon_e.ok));
                    chk("rsp_balance", 32'(rsp_balance), 32'(mon_e.bal));
                end
                chk("rsp_has_grant", 32'(gq.size() != 0), 1);
                if (gq.size() != 0) chk("rsp_latency", 32'(cyc - gq.pop_front()), 3);
            end
        end
    end

    task automatic wait_grant(input int t);
        int n = 0;
        @(negedge clk);
        while (req_ready[t] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("grant_seen", 32'(req_ready[t]), 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", 32'(busy), 0);
    endtask

    task automatic set_req(input int t, input logic [1:0] op, input int acct, input int amt);
        req_op[2*t +: 2]             = op;
        req_acct[ACCT_W*t +: ACCT_W] = ACCT_W'(acct);
        req_amt[AMT_W*t +: AMT_W]    = AMT_W'(amt);
    endtask

    task automatic load(input int acct, input int val);
        cfg_we      = 1'b1;
        cfg_acct    = ACCT_W'(acct);
        cfg_balance = BAL_W'(val);
        @(negedge clk);
        cfg_we      = 1'b0;
    endtask

    task automatic push_exp(input int t, input logic ok, input int bal);
        exp_t e;
        e.term = 3'(t);
        e.ok   = ok;
        e.bal  = BAL_W'(bal);
        exp_q.push_back(e);
    endtask

    // One transaction; poke drives a cfg write while busy, which must be ignored
    task automatic txn(input int t, input logic [1:0] op, input int acct, input int amt,
                       input logic eok, input int ebal, input bit poke);
        push_exp(t, eok, ebal);
        set_req(t, op, acct, amt);
        req_valid[t] = 1'b1;
        wait_grant(t);
        @(posedge clk);
        #1 req_valid[t] = 1'b0;
        if (poke) begin
            cfg_we      = 1'b1;
            cfg_acct    = 3'd5;
            cfg_balance = 18'd777;
            @(posedge clk);
            #1 cfg_we = 1'b0;
        end
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int order[5] = '{0, 1, 2, 3, 0};
        int prev;
        int n;
        rst = 1'b1;
        req_valid = '0; req_op = '0; req_acct = '0; req_amt = '0;
        cfg_we = 1'b0; cfg_acct = '0; cfg_balance = '0;
        repeat (2) @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 0);
        chk("reset_rsp_valid", 32'(rsp_valid), 0);
        chk("reset_rsp_ok", 32'(rsp_ok), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_rsp_term", 32'(rsp_term), 0);
        chk("reset_rsp_balance", 32'(rsp_balance), 0);

        // All four terminals deposit into acct 0 continuously from reset
        set_req(0, OP_DEP, 0, 10);
        set_req(1, OP_DEP, 0, 20);
        set_req(2, OP_DEP, 0, 30);
        set_req(3, OP_DEP, 0, 40);
        req_valid = 4'hF;
        push_exp(0, 1'b1, 10);
        push_exp(1, 1'b1, 30);
        push_exp(2, 1'b1, 60);
        push_exp(3, 1'b1, 100);
        push_exp(0, 1'b1, 110);
        @(negedge clk);
        rst = 1'b0;
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (req_ready == '0 && n < 30) begin
                @(negedge clk);
                n++;
            end
            chk("rr_grant", 32'(req_ready), 32'(1) << order[k]);
            if (k > 0) chk("rr_spacing", 32'(cyc - prev), 4);
            prev = cyc;
            if (k < 4) @(negedge clk);
        end
        @(posedge clk);
        #1 req_valid = '0;
        wait_idle();

        // Directed single transactions
        load(2, 135000);
        txn(0, OP_BAL, 2, 0,    1'b1, 135000, 0);
        txn(1, OP_DEP, 2, 2000, 1'b1, 137000, 0);
        txn(1, OP_DEP, 2, 2001, 1'b0, 137000, 0);
        txn(0, OP_BAL, 2, 0,    1'b1, 137000, 0);
        load(3, 262000);
        txn(2, OP_DEP, 3, 500,  1'b0, 262000, 0);
        txn(2, OP_DEP, 3, 143,  1'b1, 262143, 0);
        load(4, 100);
        txn(3, OP_WDR, 4, 100,  1'b1, 0, 0);
        txn(3, OP_WDR, 4, 1,    1'b0, 0, 0);
        txn(1, OP_RSV, 2, 5,    1'b0, 137000, 0);
        load(7, 999);
        txn(0, OP_BAL, 7, 0,    1'b0, 0, 0);
        txn(2, OP_DEP, 6, 10,   1'b0, 0, 0);
        txn(3, OP_BAL, 5, 0,    1'b1, 0, 1);
        txn(3, OP_BAL, 5, 0,    1'b1, 0, 0);
        txn(0, OP_BAL, 0, 0,    1'b1, 110, 0);

        // Reset during EXEC of a withdraw: no response, store cleared
        load(1, 500);
        set_req(2, OP_WDR, 1, 50);
        req_valid[2] = 1'b1;
        wait_grant(2);
        @(posedge clk);
        #1 req_valid[2] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("busy_in_exec", 32'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        txn(2, OP_BAL, 1, 0, 1'b1, 0, 0);
        txn(0, OP_BAL, 2, 0, 1'b1, 0, 0);

        // Logging mix: three accepted deposits, one rejected withdraw, one balance
        txn(0, OP_DEP, 0, 5,   1'b1, 5,  0);
        txn(1, OP_DEP, 0, 6,   1'b1, 11, 0);
        txn(2, OP_DEP, 0, 7,   1'b1, 18, 0);
        txn(3, OP_WDR, 0, 100, 1'b0, 18, 0);
        txn(0, OP_BAL, 0, 0,   1'b1, 18, 0);
`ifdef ATM_TXN_LOG_EN
        chk("txn_count", 32'(txn_count), 3);
        chk("last_term", 32'(last_term), 2);
`endif

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_atm_txn_arbiter
`default_nettype wire
